scan_receiver: RTL and testbench

Processor-side consumer for the dual-scanner subsystem. It issues the start-scanning pulse and watches the combined ready-to-transfer flag. It requests a transfer only when it has room, captures a fixed-length frame from the scanner data bus into an internal FIFO, and computes a per-frame checksum and frame count. Captured bytes drain to a host through a valid/ready port.

---
 rtl/scan_rx_pkg.sv | 21 ++
 rtl/scan_fifo.sv | 57 +++++
 rtl/scan_receiver.sv | 123 ++++++++++++
 tb/tb_scan_receiver.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_rx_pkg.sv
// Shared types and defaults for the scanner receive path.
package scan_rx_pkg;
  localparam int BYTE_W         = 8;
  localparam int FRAME_LEN_DEF  = 8;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int XFER_LAT_DEF   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_LAT,
    ST_CAPTURE,
    ST_DONE,
    ST_COOL
  } state_e;

  function automatic logic [BYTE_W-1:0] sum8(input logic [BYTE_W-1:0] a,
                                             input logic [BYTE_W-1:0] b);
    return a + b;
  endfunction
endpackage

// File: rtl/scan_fifo.sv
// Show-ahead FIFO: head byte is held in a register so data_o is glitch-free.
module scan_fifo
  import scan_rx_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] din_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [BYTE_W-1:0] data_o,
  output logic [CW-1:0]     free_o
);
  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [CW-1:0]     cnt_q;
  logic [BYTE_W-1:0] head_q;
  logic              do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
  assign rd_nxt  = rd_ptr_q + AW'(1);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      // Head follows the incoming byte when it becomes the only entry.
      if (do_push && ((cnt_q == '0) || (do_pop && (cnt_q == CW'(1)))))
        head_q <= din_i;
      else if (do_pop && (cnt_q > CW'(1)))
        head_q <= mem_q[rd_nxt];
    end
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = head_q;
  assign free_o  = CW'(DEPTH) - cnt_q;
endmodule

// File: rtl/scan_receiver.sv
// Requests scanner frames when the FIFO has room, captures them with a
// running checksum and frame counter, and drains bytes to the host.
module scan_receiver
  import scan_rx_pkg::*;
#(
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int XFER_LAT   = XFER_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_req,
  output logic              start_scanning,
  input  logic              ready_to_transfer,
  output logic              transfer,
  input  logic [BYTE_W-1:0] scan_data,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_done,
  output logic [BYTE_W-1:0] frame_sum,
  output logic [BYTE_W-1:0] frame_count,
  output logic              busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int LW = (XFER_LAT > 1) ? $clog2(XFER_LAT) : 1;

  state_e            state_q, state_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [BYTE_W-1:0] run_sum_q, run_sum_d;
  logic [BYTE_W-1:0] frame_sum_q, frame_sum_d;
  logic [BYTE_W-1:0] frame_count_q, frame_count_d;
  logic              start_req_q, start_scanning_q;
  logic              push;
  logic [CW-1:0]     fifo_free;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      lat_q            <= '0;
      idx_q            <= '0;
      run_sum_q        <= '0;
      frame_sum_q      <= '0;
      frame_count_q    <= '0;
      start_req_q      <= 1'b0;
      start_scanning_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      lat_q            <= lat_d;
      idx_q            <= idx_d;
      run_sum_q        <= run_sum_d;
      frame_sum_q      <= frame_sum_d;
      frame_count_q    <= frame_count_d;
      start_req_q      <= start_req;
      start_scanning_q <= start_req & ~start_req_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    lat_d         = lat_q;
    idx_d         = idx_q;
    run_sum_d     = run_sum_q;
    frame_sum_d   = frame_sum_q;
    frame_count_d = frame_count_q;
    push          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ready_to_transfer && (fifo_free >= CW'(FRAME_LEN))) state_d = ST_REQ;
      end
      ST_REQ: begin
        lat_d     = LW'(XFER_LAT - 1);
        idx_d     = '0;
        run_sum_d = '0;
        state_d   = (XFER_LAT == 1) ? ST_CAPTURE : ST_LAT;
      end
      ST_LAT: begin
        // Leaving as the counter reaches zero puts byte 0 on the bus next cycle.
        lat_d = lat_q - LW'(1);
        if (lat_q == LW'(1)) begin
          idx_d     = '0;
          run_sum_d = '0;
          state_d   = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        push      = 1'b1;
        run_sum_d = sum8(run_sum_q, scan_data);
        idx_d     = idx_q + IW'(1);
        if (idx_q == IW'(FRAME_LEN - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        frame_sum_d   = run_sum_q;
        frame_count_d = frame_count_q + 8'd1;
        state_d       = ST_COOL;
      end
      ST_COOL: begin
        if (!ready_to_transfer) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  scan_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .push_i (push),
    .din_i  (scan_data),
    .pop_i  (out_ready),
    .valid_o(out_valid),
    .data_o (out_data),
    .free_o (fifo_free)
  );

  assign start_scanning = start_scanning_q;
  assign transfer       = (state_q == ST_REQ);
  assign frame_done     = (state_q == ST_DONE);
  assign frame_sum      = frame_sum_q;
  assign frame_count    = frame_count_q;
  assign busy           = (state_q != ST_IDLE);
endmodule

// File: tb/tb_scan_receiver.sv
// Directed bench: frame table plus hand-written backpressure, flag, wrap and reset sequences.
module tb_scan_receiver;
  localparam int FL  = 8;
  localparam int LAT = 2;

  logic       clk = 1'b0, rst = 1'b0, start_req = 1'b0, rtt = 1'b0, out_ready = 1'b0;
  logic [7:0] scan_data = 8'h00;
  logic       start_scanning, transfer, out_valid, frame_done, busy;
  logic [7:0] out_data, frame_sum, frame_count;

  scan_receiver #(.FRAME_LEN(FL), .FIFO_DEPTH(16), .XFER_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start_req(start_req), .start_scanning(start_scanning),
    .ready_to_transfer(rtt), .transfer(transfer), .scan_data(scan_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .frame_done(frame_done), .frame_sum(frame_sum), .frame_count(frame_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  sum;
    logic [7:0]  cnt;
  } vec_t;
  vec_t vecs [5];

  int cyc = 0, n_xfer = 0, n_done = 0, n_start = 0, start_cyc = -1, xfer_cyc = -1000;
  int passed = 0, total = 0;
  logic [63:0] frame_bytes = 64'h0;
  logic [7:0]  rxq [$];
  logic [7:0]  expq [$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scanner model and output monitor, both mid-cycle.
  initial forever begin
    @(negedge clk);
    if (transfer) begin n_xfer++; xfer_cyc = cyc; end
    if (frame_done) n_done++;
    if (start_scanning) begin n_start++; start_cyc = cyc; end
    if (out_valid && out_ready) rxq.push_back(out_data);
    if ((cyc - xfer_cyc >= LAT) && (cyc - xfer_cyc < LAT + FL))
      scan_data = frame_bytes[8*(cyc - xfer_cyc - LAT) +: 8];
    else
      scan_data = 8'hEE;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int base, input string nm);
    int k = 0;
    while (n_done <= base && k < 200) begin tick(1); k++; end
    if (n_done <= base) begin
      total++;
      $display("FAIL %s: frame_done timeout got %0d expected >%0d", nm, n_done, base);
    end
  endtask

  task automatic wait_xfer(input int base, input string nm);
    int k = 0;
    while (n_xfer <= base && k < 200) begin tick(1); k++; end
    if (n_xfer <= base) begin
      total++;
      $display("FAIL %s: transfer timeout got %0d expected >%0d", nm, n_xfer, base);
    end
  endtask

  task automatic load_frame(input logic [63:0] d);
    frame_bytes = d;
    for (int k = 0; k < FL; k++) expq.push_back(d[8*k +: 8]);
  endtask

  task automatic run_frame(input logic [63:0] d, input string nm);
    int b;
    b = n_done;
    load_frame(d);
    rtt = 1'b1;
    wait_done(b, nm);
    rtt = 1'b0;
    tick(2);
  endtask

  task automatic stream_check(input string nm);
    int mm = 0;
    chk({nm, " size"}, rxq.size(), expq.size());
    for (int i = 0; i < rxq.size() && i < expq.size(); i++)
      if (rxq[i] !== expq[i]) mm++;
    chk({nm, " bytes"}, mm, 0);
    rxq.delete();
    expq.delete();
  endtask

  task automatic reset_outputs_check(input string nm);
    chk({nm, " out_valid"}, out_valid, 0);
    chk({nm, " out_data"}, out_data, 0);
    chk({nm, " frame_sum"}, frame_sum, 0);
    chk({nm, " frame_count"}, frame_count, 0);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " transfer"}, transfer, 0);
    chk({nm, " frame_done"}, frame_done, 0);
    chk({nm, " start_scanning"}, start_scanning, 0);
  endtask

  initial begin
    int b, d, c;
    vecs[0] = '{data: 64'h0807060504030201, sum: 8'h24, cnt: 8'd1};
    vecs[1] = '{data: 64'hFFFFFFFFFFFFFFFF, sum: 8'hF8, cnt: 8'd2};
    vecs[2] = '{data: 64'h8080808080808080, sum: 8'h00, cnt: 8'd3};
    vecs[3] = '{data: 64'h8070605040302010, sum: 8'h40, cnt: 8'd4};
    vecs[4] = '{data: 64'h5AA55AA55AA55AA5, sum: 8'hFC, cnt: 8'd5};

    tick(3);
    reset_outputs_check("reset");
    rst = 1'b1;
    tick(2);
    out_ready = 1'b1;

    for (int i = 0; i < 5; i++) begin
      b = n_xfer;
      rxq.delete();
      expq.delete();
      run_frame(vecs[i].data, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d frame_sum", i), frame_sum, vecs[i].sum);
      chk($sformatf("vec%0d frame_count", i), frame_count, vecs[i].cnt);
      chk($sformatf("vec%0d transfers", i), n_xfer - b, 1);
      stream_check($sformatf("vec%0d stream", i));
    end

    // start pulse: one cycle wide, one cycle after the edge
    b = n_start;
    c = cyc;
    start_req = 1'b1;
    tick(10);
    start_req = 1'b0;
    tick(2);
    chk("start pulses", n_start - b, 1);
    chk("start cycle", start_cyc, c + 1);

    // backpressure: two frames fill the FIFO, third waits for 8 free entries
    out_ready = 1'b0;
    b = n_xfer;
    run_frame(64'h0807060504030201, "bp A");
    chk("bp A out_valid", out_valid, 1);
    run_frame(64'h1122334455667788, "bp B");
    chk("bp two transfers", n_xfer - b, 2);
    load_frame(64'h8070605040302010);
    rtt = 1'b1;
    tick(30);
    chk("bp full no transfer", n_xfer - b, 2);
    chk("bp full idle", busy, 0);
    out_ready = 1'b1;
    tick(7);
    out_ready = 1'b0;
    tick(10);
    chk("bp 7 drained no transfer", n_xfer - b, 2);
    chk("bp 7 popped", rxq.size(), 7);
    d = n_done;
    out_ready = 1'b1;
    wait_done(d, "bp C");
    rtt = 1'b0;
    tick(25);
    chk("bp third transfer", n_xfer - b, 3);
    chk("bp drained", out_valid, 0);
    chk("bp frame_count", frame_count, 8);
    stream_check("bp stream");

    // flag held high after DONE blocks re-request
    b = n_xfer;
    d = n_done;
    load_frame(64'h0807060504030201);
    rtt = 1'b1;
    wait_done(d, "flag A");
    tick(20);
    chk("flag hold transfers", n_xfer - b, 1);
    chk("flag hold busy", busy, 1);
    rtt = 1'b0;
    tick(3);
    chk("flag low idle", busy, 0);
    chk("flag low transfers", n_xfer - b, 1);
    run_frame(64'h0102030405060708, "flag B");
    chk("flag rerequest", n_xfer - b, 2);

    // flag dropped mid-capture: frame still completes
    d = n_done;
    b = n_xfer;
    load_frame(64'hF0E0D0C0B0A09080);
    rtt = 1'b1;
    wait_xfer(b, "drop xfer");
    tick(4);
    rtt = 1'b0;
    wait_done(d, "drop done");
    tick(3);
    chk("drop frame_sum", frame_sum, 8'hC0);
    chk("drop frame_count", frame_count, 11);
    stream_check("drop stream");

    // frame counter wrap
    for (int i = 0; i < 244; i++) run_frame(64'hFFFFFFFFFFFFFFFF, "wrap");
    chk("wrap count 255", frame_count, 8'd255);
    run_frame(64'h0807060504030201, "wrap last");
    chk("wrap count 0", frame_count, 8'd0);
    chk("wrap last sum", frame_sum, 8'h24);
    stream_check("wrap stream");

    // reset mid-capture discards partial frame
    b = n_xfer;
    load_frame(64'h0807060504030201);
    rtt = 1'b1;
    wait_xfer(b, "rst xfer");
    tick(4);
    chk("rst mid busy", busy, 1);
    rst = 1'b0;
    #1;
    reset_outputs_check("rst mid");
    rtt = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    rxq.delete();
    expq.delete();
    run_frame(64'h8070605040302010, "rst after");
    chk("rst after count", frame_count, 8'd1);
    chk("rst after sum", frame_sum, 8'h40);
    stream_check("rst after stream");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
